// File: rtl/gray_stream_tx.sv
// RGB565 -> 8-bit luma frame transmitter: one conversion register feeding a show-ahead FIFO.
// Latency: 2 cycles from accept to o_valid when the FIFO is empty; o_pix_ready drops when FIFO plus conversion slot are full.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          clr,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_wr  = wr_vld && (count != (AW+1)'(DEPTH));
    assign do_rd  = rd_rdy && rd_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr && !clr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module gray_stream_tx #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_pix_valid,
    input  logic [15:0] i_rgb,
    output logic        o_pix_ready,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_gray,
    output logic        o_end,
    output logic        o_frame_done,
    output logic        o_busy
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int FW    = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          conv_valid;
    logic [7:0]    conv_gray;
    logic          flush;
    logic          accept;
    logic          xfer;
    logic          last_xfer;
    logic [FW-1:0] fifo_count;
    logic [FW:0]   occupancy;
    logic [7:0]    fifo_head;
    logic [7:0]    r8, g8, b8;
    logic [15:0]   luma_sum;

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                state_nxt = RUN;
                flush     = 1'b1;
            end
            RUN: if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // The conversion slot counts against FIFO space so its write can never hit a full FIFO.
    assign occupancy   = {1'b0, fifo_count} + {{FW{1'b0}}, conv_valid};
    assign o_pix_ready = (state == RUN) && (in_cnt < CW'(TOTAL)) &&
                         (occupancy < (FW+1)'(FIFO_DEPTH));
    assign accept      = i_pix_valid && o_pix_ready;
    assign xfer        = o_valid && i_ready;
    assign last_xfer   = xfer && (out_cnt == CW'(TOTAL - 1));
    assign o_busy      = (state == RUN);
    assign o_gray      = o_valid ? fifo_head : 8'd0;
    assign o_end       = o_valid && (out_cnt == CW'(TOTAL - 1));

    assign r8       = {i_rgb[15:11], i_rgb[15:13]};
    assign g8       = {i_rgb[10:5],  i_rgb[10:9]};
    assign b8       = {i_rgb[4:0],   i_rgb[4:2]};
    assign luma_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_cnt       <= '0;
            out_cnt      <= '0;
            conv_valid   <= 1'b0;
            conv_gray    <= 8'd0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= last_xfer;
            if (flush) begin
                in_cnt     <= '0;
                out_cnt    <= '0;
                conv_valid <= 1'b0;
            end else begin
                conv_valid <= accept;
                if (accept) begin
                    conv_gray <= luma_sum[15:8];
                    in_cnt    <= in_cnt + CW'(1);
                end
                if (xfer) out_cnt <= out_cnt + CW'(1);
            end
        end
    end

    fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (flush),
        .wr_vld  (conv_valid),
        .wr_dat  (conv_gray),
        .rd_rdy  (i_ready),
        .rd_vld  (o_valid),
        .rd_dat  (fifo_head),
        .count   (fifo_count)
    );
endmodule
